// File: rtl/avg_sched_pkg.sv
// Shared widths, defaults and per-channel state type for the multi-channel
// leaky-integrator averager / peak tracker.
package avg_sched_pkg;

   localparam int NBITS   = 16;
   localparam int ABITS   = 8;
   localparam int ACC_W   = NBITS + ABITS;
   localparam int NCH_DEF = 4;

   localparam logic [NBITS-1:0] MAX_INIT_DEF = 16'd5;

   // Channel-select width; a single channel still needs a 1-bit select.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CH_W = ch_w(NCH_DEF);

   typedef struct packed {
      logic [ACC_W-1:0] acc;
      logic [NBITS-1:0] max;
   } ch_state_t;

endpackage

// File: rtl/avg_update.sv
// One leaky-integrator / decaying-peak step for a single channel.
// Everything is unsigned; the accumulator wraps modulo 2^ACC_W.
module avg_update
   import avg_sched_pkg::*;
(
   input  logic [ACC_W-1:0] acc_i,
   input  logic [NBITS-1:0] max_i,
   input  logic [NBITS-1:0] amp_i,
   output logic [ACC_W-1:0] acc_o,
   output logic [NBITS-1:0] max_o,
   output logic [NBITS-1:0] avg_o
);

   always_comb begin
      acc_o = acc_i + ACC_W'(amp_i) - (acc_i >> ABITS);
      max_o = (amp_i > max_i) ? amp_i : max_i - (max_i >> ABITS);
      avg_o = acc_o[ACC_W-1:ABITS];
   end

endmodule

// File: rtl/avg_channel_scheduler.sv
// Round-robin time-multiplexing of one avg_update datapath over NCH channels,
// with per-update result strobes and a registered random-access read port.
module avg_channel_scheduler
   import avg_sched_pkg::*;
#(
   parameter  int               NCH      = NCH_DEF,
   parameter  logic [NBITS-1:0] MAX_INIT = MAX_INIT_DEF,
   localparam int               SEL_W    = ch_w(NCH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH-1:0]         s_valid,
   output logic [NCH-1:0]         s_ready,
   input  logic [NCH*NBITS-1:0]   s_data,
   input  logic [NCH-1:0]         clr_ch,
   input  logic [SEL_W-1:0]       rd_ch,
   output logic [NBITS-1:0]       rd_avg,
   output logic [NBITS-1:0]       rd_max,
   output logic                   upd_valid,
   output logic [SEL_W-1:0]       upd_ch,
   output logic [NBITS-1:0]       upd_avg,
   output logic [NBITS-1:0]       upd_max
);

   ch_state_t        state_q [NCH];
   logic [SEL_W-1:0] ptr_q;
   logic             s1_valid_q;
   logic [SEL_W-1:0] s1_ch_q;
   logic [NBITS-1:0] s1_amp_q;

   logic             upd_valid_q;
   logic [SEL_W-1:0] upd_ch_q;
   logic [NBITS-1:0] upd_avg_q, upd_max_q;
   logic [NBITS-1:0] rd_avg_q, rd_max_q;

   logic             gnt_vld;
   logic [SEL_W-1:0] gnt_ch;
   logic [SEL_W:0]   start_idx, sum_idx;
   logic [2*NCH-1:0] dbl_valid;
   logic [NCH-1:0]   rot_valid;
   logic [SEL_W-1:0] rot_off;

   ch_state_t        cur_st;
   logic [ACC_W-1:0] acc_d;
   logic [NBITS-1:0] max_d, avg_d;

   // Arbiter: rotate so ptr+1 sits at bit 0, take the lowest set bit, un-rotate.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      gnt_vld   = 1'b0;
      rot_off   = '0;
      s_ready   = '0;
      start_idx = (ptr_q == SEL_W'(NCH-1)) ? '0 : {1'b0, ptr_q} + (SEL_W+1)'(1);
      dbl_valid = {s_valid, s_valid} >> start_idx;
      rot_valid = dbl_valid[NCH-1:0];
      for (int k = NCH-1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            gnt_vld = 1'b1;
            rot_off = SEL_W'(k);
         end
      end
      sum_idx = start_idx + {1'b0, rot_off};
      if (sum_idx >= (SEL_W+1)'(NCH)) sum_idx = sum_idx - (SEL_W+1)'(NCH);
      gnt_ch = sum_idx[SEL_W-1:0];
      for (int i = 0; i < NCH; i++) s_ready[i] = gnt_vld && (gnt_ch == SEL_W'(i));
   end

   // The previous stage-1 write has already landed, so back-to-back samples on
   // one channel see fresh state without forwarding.
   assign cur_st = state_q[s1_ch_q];

   avg_update u_update (
      .acc_i (cur_st.acc),
      .max_i (cur_st.max),
      .amp_i (s1_amp_q),
      .acc_o (acc_d),
      .max_o (max_d),
      .avg_o (avg_d)
   );

   // NOTE: the channel state array is small flop storage, so it is reset like
   // any other register rather than treated as an un-resettable RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= SEL_W'(NCH-1);
         s1_valid_q  <= 1'b0;
         s1_ch_q     <= '0;
         s1_amp_q    <= '0;
         upd_valid_q <= 1'b0;
         upd_ch_q    <= '0;
         upd_avg_q   <= '0;
         upd_max_q   <= '0;
         rd_avg_q    <= '0;
         rd_max_q    <= '0;
         for (int i = 0; i < NCH; i++) state_q[i] <= '{acc: '0, max: MAX_INIT};
      end else begin
         s1_valid_q <= gnt_vld;
         if (gnt_vld) begin
            s1_ch_q  <= gnt_ch;
            s1_amp_q <= s_data[gnt_ch*NBITS +: NBITS];
            ptr_q    <= gnt_ch;
         end

         // A clear on the channel being written wins over the update.
         for (int i = 0; i < NCH; i++) begin
            if (clr_ch[i])
               state_q[i] <= '{acc: '0, max: MAX_INIT};
            else if (s1_valid_q && (s1_ch_q == SEL_W'(i)))
               state_q[i] <= '{acc: acc_d, max: max_d};
         end

         upd_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            upd_ch_q  <= s1_ch_q;
            upd_avg_q <= clr_ch[s1_ch_q] ? '0 : avg_d;
            upd_max_q <= clr_ch[s1_ch_q] ? MAX_INIT : max_d;
         end

         if (int'(rd_ch) < NCH) begin
            rd_avg_q <= state_q[rd_ch].acc[ACC_W-1:ABITS];
            rd_max_q <= state_q[rd_ch].max;
         end else begin
            rd_avg_q <= '0;
            rd_max_q <= '0;
         end
      end
   end

   assign upd_valid = upd_valid_q;
   assign upd_ch    = upd_ch_q;
   assign upd_avg   = upd_avg_q;
   assign upd_max   = upd_max_q;
   assign rd_avg    = rd_avg_q;
   assign rd_max    = rd_max_q;

endmodule

// File: tb/tb_avg_channel_scheduler.sv
// Scoreboard bench for avg_channel_scheduler: a cycle model pushes expected
// update results, an independent monitor pops and compares on upd_valid.
module tb_avg_channel_scheduler;
   import avg_sched_pkg::*;

   localparam int NCH = NCH_DEF;
   localparam int SW  = CH_W;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NCH-1:0]       s_valid, s_ready, clr_ch;
   logic [NCH*NBITS-1:0] s_data;
   logic [SW-1:0]        rd_ch, upd_ch;
   logic [NBITS-1:0]     rd_avg, rd_max, upd_avg, upd_max;
   logic                 upd_valid;

   avg_channel_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .clr_ch    (clr_ch),
      .rd_ch     (rd_ch),
      .rd_avg    (rd_avg),
      .rd_max    (rd_max),
      .upd_valid (upd_valid),
      .upd_ch    (upd_ch),
      .upd_avg   (upd_avg),
      .upd_max   (upd_max)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0, cyc = 0, upd_seen = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int ch;
      int avg;
      int mx;
      int due;
   } exp_t;
   exp_t sb[$];

   // Reference state
   logic [ACC_W-1:0] m_acc [NCH];
   logic [NBITS-1:0] m_max [NCH];
   logic [NBITS-1:0] d     [NCH];
   int               m_ptr, m_s1_ch, m_s1_due;
   bit               m_s1_v;
   logic [NBITS-1:0] m_s1_amp;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int model_grant();
      for (int k = 1; k <= NCH; k++) begin
         int c = (m_ptr + k) % NCH;
         if (s_valid[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_acc[i] = '0;
         m_max[i] = MAX_INIT_DEF;
      end
      m_ptr  = NCH - 1;
      m_s1_v = 1'b0;
   endtask

   // Called just after a falling edge with inputs set; models the next rising
   // edge and returns after the following falling edge.
   task automatic tick();
      int g;
      logic [ACC_W-1:0] na;
      logic [NBITS-1:0] nm;
      for (int i = 0; i < NCH; i++) s_data[i*NBITS +: NBITS] = d[i];
      #1;
      if (rst) begin
         model_reset();
      end else begin
         g = model_grant();
         check("s_ready", 32'(s_ready), (g < 0) ? 32'd0 : (32'd1 << g));
         if (m_s1_v) begin
            if (clr_ch[m_s1_ch]) begin
               sb.push_back('{ch: m_s1_ch, avg: 0, mx: int'(MAX_INIT_DEF), due: m_s1_due});
            end else begin
               na = m_acc[m_s1_ch] + ACC_W'(m_s1_amp) - (m_acc[m_s1_ch] >> ABITS);
               nm = (m_s1_amp > m_max[m_s1_ch]) ? m_s1_amp
                                                : m_max[m_s1_ch] - (m_max[m_s1_ch] >> ABITS);
               m_acc[m_s1_ch] = na;
               m_max[m_s1_ch] = nm;
               sb.push_back('{ch: m_s1_ch, avg: int'(na >> ABITS), mx: int'(nm), due: m_s1_due});
            end
         end
         for (int i = 0; i < NCH; i++) begin
            if (clr_ch[i]) begin
               m_acc[i] = '0;
               m_max[i] = MAX_INIT_DEF;
            end
         end
         if (g >= 0) begin
            m_s1_v   = 1'b1;
            m_s1_ch  = g;
            m_s1_amp = d[g];
            m_s1_due = cyc + 2;
            m_ptr    = g;
         end else begin
            m_s1_v = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic rd_check(input int c, input int exp_avg, input int exp_max);
      rd_ch = SW'(c);
      tick();
      check($sformatf("rd_avg[%0d]", c), 32'(rd_avg), exp_avg);
      check($sformatf("rd_max[%0d]", c), 32'(rd_max), exp_max);
   endtask

   // Monitor: every upd_valid must match the oldest expected update.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (upd_valid === 1'b1) begin
            upd_seen++;
            if (sb.size() == 0) begin
               check("upd_unexpected", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("upd_ch",    32'(upd_ch),  e.ch);
               check("upd_avg",   32'(upd_avg), e.avg);
               check("upd_max",   32'(upd_max), e.mx);
               check("upd_cycle", cyc,          e.due);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n_before;
      s_valid = '0;
      clr_ch  = '0;
      rd_ch   = '0;
      for (int i = 0; i < NCH; i++) d[i] = '0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      check("rst_upd_valid", 32'(upd_valid), 0);
      check("rst_upd_ch",    32'(upd_ch),    0);
      check("rst_upd_avg",   32'(upd_avg),   0);
      check("rst_upd_max",   32'(upd_max),   0);
      check("rst_rd_avg",    32'(rd_avg),    0);
      check("rst_rd_max",    32'(rd_max),    0);
      s_valid = '1;
      #1 check("rst_first_grant", 32'(s_ready), 32'b0001);
      s_valid = '0;

      // ch0: 256 then 0
      d[0] = 16'd256; s_valid = 4'b0001; tick();
      s_valid = '0; repeat (2) tick();
      rd_check(0, 1, 256);
      d[0] = 16'd0; s_valid = 4'b0001; tick();
      s_valid = '0; repeat (2) tick();
      rd_check(0, 0, 255);

      // ch3 back-to-back: acc 256, 511, 766, 1020
      d[3] = 16'd256; s_valid = 4'b1000;
      repeat (4) tick();
      s_valid = '0; repeat (2) tick();
      rd_check(3, 3, 255);

      // All channels valid: strict rotation starting after ch3
      d[0] = 16'd100; d[1] = 16'd200; d[2] = 16'd300; d[3] = 16'd400;
      s_valid = '1;
      for (int i = 0; i < 16; i++) begin
         #1 check("rr_grant", 32'(s_ready), 32'd1 << (i % NCH));
         tick();
      end
      s_valid = '0; repeat (2) tick();

      // Clear colliding with a ch1 write; sample in the clear cycle lands after it
      d[1] = 16'd700; s_valid = 4'b0010; tick();
      d[1] = 16'd512; clr_ch = 4'b0010; tick();
      s_valid = '0; clr_ch = '0; repeat (2) tick();
      rd_check(1, 2, 512);

      // Reset with a sample in stage 1
      d[0] = 16'd300; s_valid = 4'b0001; tick();
      s_valid = '0; rst = 1'b1; n_before = upd_seen;
      repeat (2) tick();
      rst = 1'b0; repeat (2) tick();
      check("rst_no_upd", upd_seen, n_before);
      for (int c = 0; c < NCH; c++) rd_check(c, 0, 5);
      s_valid = '1;
      #1 check("rst_grant_ch0", 32'(s_ready), 32'b0001);
      s_valid = '0;

      // ch2 constant 1000 for 3000 samples
      d[2] = 16'd1000; s_valid = 4'b0100;
      repeat (3000) tick();
      s_valid = '0; repeat (2) tick();
      rd_ch = SW'(2); tick();
      check("avg_converged", 32'((rd_avg >= 16'd999) && (rd_avg <= 16'd1001)), 1);
      check("rd_max[2]", 32'(rd_max), 997);
      rd_check(0, 0, 5);
      rd_check(1, 0, 5);
      rd_check(3, 0, 5);

      repeat (3) tick();
      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
